// File: rtl/seg7_reader.sv
// Recovers BCD digits from a multiplexed 4-digit seven-segment bus, with glitch filtering
// and a valid/ready update channel. Define SEG7_READER_HEX_EN to also accept the A..F glyphs.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no update outstanding, next commit loads payload
// ST_PEND    | update offered on upd_*, waiting for upd_ready
module seg7_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_en,
    output logic [15:0] digits,
    output logic [3:0]  dig_err,
    output logic        upd_valid,
    input  logic        upd_ready,
    output logic [1:0]  upd_idx,
    output logic [3:0]  upd_code,
    output logic        upd_err,
    output logic        overflow
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_PEND = 1'b1;

    // Commit fires on the edge that would bring cnt up to STABLE_CYCLES.
    localparam logic [3:0] CNT_COMMIT = 4'(STABLE_CYCLES - 1);

    logic [10:0] pair_q;
    logic [3:0]  cnt;
    logic        armed;
    logic        state;

    logic        same;
    logic        en_onehot;
    logic        commit;
    logic [1:0]  commit_idx;
    logic [3:0]  dec_val;
    logic        dec_err;

    assign same      = ({dig_en, seg_in} == pair_q);
    assign en_onehot = (dig_en != 4'd0) && ((dig_en & (dig_en - 4'd1)) == 4'd0);
    assign commit    = armed && same && (cnt == CNT_COMMIT) && en_onehot && (seg_in != 7'd0);
    assign upd_valid = (state == ST_PEND);

    always_comb begin
        commit_idx = 2'd0;
        case (dig_en)
            4'b0010: commit_idx = 2'd1;
            4'b0100: commit_idx = 2'd2;
            4'b1000: commit_idx = 2'd3;
            default: commit_idx = 2'd0;
        endcase
    end

    always_comb begin
        dec_val = 4'd0;
        dec_err = 1'b0;
        case (seg_in)
            7'h3F: dec_val = 4'd0;
            7'h06: dec_val = 4'd1;
            7'h5B: dec_val = 4'd2;
            7'h4F: dec_val = 4'd3;
            7'h66: dec_val = 4'd4;
            7'h6D: dec_val = 4'd5;
            7'h7D: dec_val = 4'd6;
            7'h07: dec_val = 4'd7;
            7'h7F: dec_val = 4'd8;
            7'h6F: dec_val = 4'd9;
`ifdef SEG7_READER_HEX_EN
            7'h77: dec_val = 4'hA;
            7'h7C: dec_val = 4'hB;
            7'h39: dec_val = 4'hC;
            7'h5E: dec_val = 4'hD;
            7'h79: dec_val = 4'hE;
            7'h71: dec_val = 4'hF;
`endif
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_q <= '0;
            cnt    <= '0;
            armed  <= 1'b0;
        end else begin
            pair_q <= {dig_en, seg_in};
            if (!same) begin
                cnt   <= 4'd1;
                armed <= 1'b1;
            end else begin
                if (cnt != 4'd15)
                    cnt <= cnt + 4'd1;
                if (commit)
                    armed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits  <= '0;
            dig_err <= '0;
        end else if (commit) begin
            digits[{commit_idx, 2'b00} +: 4] <= dec_val;
            dig_err[commit_idx]              <= dec_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            upd_idx  <= '0;
            upd_code <= '0;
            upd_err  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (commit) begin
                        state    <= ST_PEND;
                        upd_idx  <= commit_idx;
                        upd_code <= dec_val;
                        upd_err  <= dec_err;
                    end
                end
                default: begin
                    if (upd_ready && commit) begin
                        upd_idx  <= commit_idx;
                        upd_code <= dec_val;
                        upd_err  <= dec_err;
                    end else if (upd_ready) begin
                        state <= ST_IDLE;
                    end else if (commit) begin
                        overflow <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: directed scenarios plus random bus traffic,
// compared every cycle against a history-based reference model.
module tb_seg7_reader;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = '0;
    logic [3:0]  dig_en = '0;
    logic        upd_ready = 1'b0;
    logic [15:0] digits;
    logic [3:0]  dig_err;
    logic        upd_valid;
    logic [1:0]  upd_idx;
    logic [3:0]  upd_code;
    logic        upd_err;
    logic        overflow;

    seg7_reader #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en(dig_en),
        .digits(digits), .dig_err(dig_err), .upd_valid(upd_valid),
        .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_code(upd_code),
        .upd_err(upd_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [10:0] hist[$];
    logic [3:0]  m_dig[4];
    logic        m_err[4];
    logic        m_pend, m_perr, m_ovf;
    logic [1:0]  m_pidx;
    logic [3:0]  m_pcode;
    logic [6:0]  glyph[16];

    function automatic logic [4:0] ref_decode(input logic [6:0] seg);
        int limit;
`ifdef SEG7_READER_HEX_EN
        limit = 16;
`else
        limit = 10;
`endif
        for (int i = 0; i < limit; i++)
            if (glyph[i] == seg) return {1'b0, 4'(i)};
        return 5'b1_0000;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back(11'd0);
        for (int i = 0; i < 4; i++) begin m_dig[i] = 4'd0; m_err[i] = 1'b0; end
        m_pend = 0; m_perr = 0; m_ovf = 0; m_pidx = 0; m_pcode = 0;
    endtask

    // Commit when the last S sampled pairs match and the one before them differs.
    task automatic model_edge();
        logic [10:0] p;
        logic        c;
        logic [4:0]  d;
        int          idx;
        p = {dig_en, seg_in};
        hist.push_back(p);
        void'(hist.pop_front());
        c = (hist[0] != p);
        for (int i = 1; i <= S; i++) if (hist[i] != p) c = 0;
        if ($countones(dig_en) != 1 || seg_in == 7'd0) c = 0;
        idx = 0;
        for (int i = 0; i < 4; i++) if (dig_en[i]) idx = i;
        d = ref_decode(seg_in);
        if (c) begin m_dig[idx] = d[3:0]; m_err[idx] = d[4]; end
        if (m_pend && upd_ready && !c) m_pend = 0;
        else if (m_pend && !upd_ready && c) m_ovf = 1;
        else if (c) begin
            m_pend = 1; m_pidx = 2'(idx); m_pcode = d[3:0]; m_perr = d[4];
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("digits", digits, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
        check("dig_err", 16'(dig_err), 16'({m_err[3], m_err[2], m_err[1], m_err[0]}));
        check("upd_valid", 16'(upd_valid), 16'(m_pend));
        check("upd_idx", 16'(upd_idx), 16'(m_pidx));
        check("upd_code", 16'(upd_code), 16'(m_pcode));
        check("upd_err", 16'(upd_err), 16'(m_perr));
        check("overflow", 16'(overflow), 16'(m_ovf));
    endtask

    task automatic step(input logic [3:0] en, input logic [6:0] seg, input logic rdy);
        dig_en = en; seg_in = seg; upd_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic hold(input logic [3:0] en, input logic [6:0] seg, input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(en, seg, rdy);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_all", {digits[11:0], dig_err}, 16'h0);
        check("rst_ctl", 16'({upd_valid, upd_idx, upd_code, upd_err, overflow}), 16'h0);
        #1 rst = 1'b0;
    endtask

    initial begin
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        model_reset();
        #1 check_all();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Stable digit 5 on digit 2
        hold(4'b0100, 7'h6D, 1'b1, 4);
        check("stable_dig2", 16'(digits[11:8]), 16'd5);
        check("stable_pulse", 16'({upd_valid, upd_idx, upd_code}), 16'({1'b1, 2'd2, 4'd5}));
        hold(4'b0100, 7'h6D, 1'b1, 6);
        check("stable_nopulse", 16'(upd_valid), 16'd0);

        // Glitch rejection, blank and non-one-hot enables
        hold(4'b0001, 7'h3F, 1'b1, 3);
        hold(4'b0001, 7'h06, 1'b1, 4);
        check("glitch_code", 16'(upd_code), 16'd1);
        hold(4'b0001, 7'h00, 1'b1, 6);
        hold(4'b0011, 7'h5B, 1'b1, 6);
        check("glitch_dig0", 16'(digits[3:0]), 16'd1);

        // Illegal / hex glyph on digit 3
        hold(4'b1000, 7'h77, 1'b0, 4);
`ifdef SEG7_READER_HEX_EN
        check("hex_glyph", 16'({dig_err[3], upd_err, upd_code}), 16'({1'b0, 1'b0, 4'hA}));
`else
        check("bad_glyph", 16'({dig_err[3], upd_err, upd_code}), 16'({1'b1, 1'b1, 4'h0}));
`endif
        hold(4'b1000, 7'h77, 1'b1, 1);

        // Backpressure
        async_reset();
        hold(4'b0001, 7'h7F, 1'b0, 5);
        hold(4'b0010, 7'h4F, 1'b0, 5);
        check("bp_payload", 16'({upd_idx, upd_code}), 16'({2'd0, 4'd8}));
        check("bp_dig1", 16'(digits[7:4]), 16'd3);
        check("bp_ovf", 16'(overflow), 16'd1);
        step(4'b0010, 7'h4F, 1'b1);
        check("bp_release", 16'(upd_valid), 16'd0);

        // Reset while pending
        hold(4'b0100, 7'h07, 1'b0, 4);
        async_reset();

        // Full scan 9,0,7,2
        hold(4'b0001, 7'h6F, 1'b1, 6);
        hold(4'b0010, 7'h3F, 1'b1, 6);
        hold(4'b0100, 7'h07, 1'b1, 6);
        hold(4'b1000, 7'h5B, 1'b1, 6);
        check("scan_digits", digits, 16'h2709);

        // Random bus traffic
        for (int seg_i = 0; seg_i < 80; seg_i++) begin
            logic [3:0] en;
            logic [6:0] seg;
            int r;
            r = $urandom_range(0, 9);
            en = (r < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            r = $urandom_range(0, 9);
            seg = (r < 7) ? glyph[$urandom_range(0, 15)] : (r == 7) ? 7'd0 : 7'($urandom);
            r = $urandom_range(1, 7);
            for (int k = 0; k < r; k++) step(en, seg, 1'($urandom_range(0, 2) != 0));
            if (seg_i == 40) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
